// File: rtl/bin2bcd_seg_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving active-low 7-segment digits.
// Optional leading-zero blanking of the segment outputs is enabled with the macro BIN2BCD_LZB_EN.
module bin2bcd_seg_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic [1:0]            dbg_state
);

    // Decimal digits needed to hold 2^w-1, never fewer than the displayed digit count.
    function automatic int calc_nfull(input int w, input int d);
        logic [63:0] v;
        int          n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 64'd0) begin
            n++;
            v = v / 64'd10;
        end
        if (n < d) n = d;
        return n;
    endfunction

    localparam int NFULL = calc_nfull(WIDTH, DIGITS);
    localparam int AW    = 4 * NFULL;
    localparam int CW    = $clog2(WIDTH);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_sr;
    logic [AW-1:0]       r_acc;
    logic [CW-1:0]       r_cnt;

    logic [AW-1:0]       w_adj;
    logic [AW-1:0]       w_acc_next;
    logic                w_ovf;
    logic [4*DIGITS-1:0] w_bcd;
    logic [7*DIGITS-1:0] w_hex;

    assign dbg_state = r_state;

    // One double-dabble step: correct nibbles >= 5, then shift the next binary bit in.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < NFULL; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
        end
        w_acc_next = {w_adj[AW-2:0], r_sr[WIDTH-1]};
    end

    // Result formatting is taken from the post-step accumulator so outputs land with done.
    always_comb begin
        logic lead;
        w_ovf = 1'b0;
        for (int i = DIGITS; i < NFULL; i++) begin
            if (w_acc_next[4*i +: 4] != 4'd0) w_ovf = 1'b1;
        end
        w_bcd = w_ovf ? {DIGITS{4'h9}} : w_acc_next[4*DIGITS-1:0];
        w_hex = '0;
        lead  = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && (w_acc_next[4*k +: 4] == 4'd0);
            if (w_ovf) w_hex[7*k +: 7] = SEG_DASH;
`ifdef BIN2BCD_LZB_EN
            else if (lead && (k != 0)) w_hex[7*k +: 7] = SEG_BLANK;
`endif
            else w_hex[7*k +: 7] = seg7(w_acc_next[4*k +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bcd     <= '0;
            hex     <= {DIGITS{7'b1000000}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr    <= din;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        ovf     <= w_ovf;
                        bcd     <= w_bcd;
                        hex     <= w_hex;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
